// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction fetch/decode/execute sequencer. Steps through
//                FETCH -> DECODE -> EXECUTE, handles instruction fetch
//                handshakes and issues one-cycle PC actions (increment or
//                load). A return-address stack supports call/ret. Stack
//                overflow or underflow raises a sticky error and halts.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                pc_in           - current program counter value
//                pc_inc/pc_load  - one-cycle PC advance / load requests
//                pc_next         - load target, zero unless pc_load=1
//                imem_req/ack    - instruction fetch handshake
//                ir_load         - instruction register latch strobe
//                br_taken, call, ret, halt, br_target - decoded control
//                exec_done       - execution unit completion
//                stack_err       - sticky overflow/underflow flag
//                state_o         - FSM state (00 FETCH .. 11 HALT)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
   parameter int ADDR_WIDTH  = 12,
   parameter int STACK_DEPTH = 4     // power of two, 2..16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] pc_in,
   output logic                  pc_inc,
   output logic                  pc_load,
   output logic [ADDR_WIDTH-1:0] pc_next,
   output logic                  imem_req,
   input  logic                  imem_ack,
   output logic                  ir_load,
   input  logic                  br_taken,
   input  logic                  call,
   input  logic                  ret,
   input  logic                  halt,
   input  logic [ADDR_WIDTH-1:0] br_target,
   input  logic                  exec_done,
   output logic                  stack_err,
   output logic [1:0]            state_o
);

   localparam int IDX_W = $clog2(STACK_DEPTH);
   localparam int SP_W  = IDX_W + 1;   // holds 0..STACK_DEPTH inclusive

   localparam logic [SP_W-1:0]       SP_ONE   = SP_W'(1);
   localparam logic [SP_W-1:0]       SP_FULL  = SP_W'(STACK_DEPTH);
   localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   typedef enum logic [1:0] {
      S_FETCH   = 2'b00,
      S_DECODE  = 2'b01,
      S_EXECUTE = 2'b10,
      S_HALT    = 2'b11
   } state_t;

   state_t                r_state;
   logic [SP_W-1:0]       r_sp;                    // number of valid entries
   logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];

   logic [IDX_W-1:0]      w_push_idx;
   logic [IDX_W-1:0]      w_top_idx;
   logic [ADDR_WIDTH-1:0] w_ret_addr;

   // The top entry sits one below the fill count; the index wraps naturally
   // when the stack is full, which still addresses the last slot.
   assign w_push_idx = r_sp[IDX_W-1:0];
   assign w_top_idx  = w_push_idx - IDX_ONE;

   // Return address drops the carry, so a call at the last address returns to 0.
   assign w_ret_addr = pc_in + ADDR_ONE;

   // The IR latch must coincide with the ack cycle itself, so it is decoded
   // from the registered request rather than registered again. imem_req is
   // only ever high in FETCH, so stray acks elsewhere never load the IR.
   assign ir_load = imem_req & imem_ack;

   assign state_o = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_sp      <= '0;
         stack_err <= 1'b0;
         imem_req  <= 1'b0;
         pc_inc    <= 1'b0;
         pc_load   <= 1'b0;
         pc_next   <= '0;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            r_stack[i] <= '0;
         end
      end else begin
         // PC strobes are single-cycle; pc_next is only meaningful with pc_load.
         pc_inc  <= 1'b0;
         pc_load <= 1'b0;
         pc_next <= '0;

         case (r_state)
            S_FETCH: begin
               // Entering FETCH (after reset or after EXECUTE) leaves the
               // request low for one cycle so the PC update lands first.
               if (!imem_req) begin
                  imem_req <= 1'b1;
               end else if (imem_ack) begin
                  imem_req <= 1'b0;
                  r_state  <= S_DECODE;
               end
            end

            S_DECODE: begin
               r_state <= halt ? S_HALT : S_EXECUTE;
            end

            S_EXECUTE: begin
               if (exec_done) begin
                  r_state <= S_FETCH;
                  if (ret) begin
                     if (r_sp == '0) begin
                        stack_err <= 1'b1;
                        r_state   <= S_HALT;
                     end else begin
                        pc_load <= 1'b1;
                        pc_next <= r_stack[w_top_idx];
                        r_sp    <= r_sp - SP_ONE;
                     end
                  end else if (call) begin
                     if (r_sp == SP_FULL) begin
                        stack_err <= 1'b1;
                        r_state   <= S_HALT;
                     end else begin
                        r_stack[w_push_idx] <= w_ret_addr;
                        r_sp                <= r_sp + SP_ONE;
                        pc_load             <= 1'b1;
                        pc_next             <= br_target;
                     end
                  end else if (br_taken) begin
                     pc_load <= 1'b1;
                     pc_next <= br_target;
                  end else begin
                     pc_inc <= 1'b1;
                  end
               end
            end

            S_HALT: begin
               // Terminal until reset; all strobes stay at their cleared value.
               r_state <= S_HALT;
            end

            default: begin
               r_state <= S_HALT;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed self-checking bench for fetch_sequencer. Expected
//                PC actions come from a small return-stack model and are
//                queued when EXECUTE stimulus is driven; a monitor pops and
//                compares them whenever the DUT emits a PC strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

   localparam int AW    = 12;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] pc_in = '0;
   logic          pc_inc, pc_load, imem_req, ir_load, stack_err;
   logic [AW-1:0] pc_next;
   logic          imem_ack = 1'b0;
   logic          br_taken = 1'b0, call = 1'b0, ret = 1'b0, halt = 1'b0;
   logic [AW-1:0] br_target = '0;
   logic          exec_done = 1'b0;
   logic [1:0]    state_o;

   int total = 0;
   int bad   = 0;

   // Scoreboard entries are {pc_inc, pc_load, pc_next}.
   logic [AW+1:0] sb [$];
   logic [AW-1:0] model_stack [$];

   fetch_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .pc_in     (pc_in),
      .pc_inc    (pc_inc),
      .pc_load   (pc_load),
      .pc_next   (pc_next),
      .imem_req  (imem_req),
      .imem_ack  (imem_ack),
      .ir_load   (ir_load),
      .br_taken  (br_taken),
      .call      (call),
      .ret       (ret),
      .halt      (halt),
      .br_target (br_target),
      .exec_done (exec_done),
      .stack_err (stack_err),
      .state_o   (state_o)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // Monitor: strobe invariants every cycle, scoreboard compare on each strobe.
   always @(negedge clk) begin
      logic [AW+1:0] got;
      logic [AW+1:0] exp;
      if (!rst) begin
         total++;
         assert (!(pc_inc && pc_load) && (pc_load || pc_next == '0)) else begin
            bad++;
            $error("FAIL strobe_invariant observed inc=%b load=%b next=0x%0h expected exclusive strobes, next=0 without load",
                   pc_inc, pc_load, pc_next);
         end
         if (pc_inc || pc_load) begin
            got = {pc_inc, pc_load, pc_next};
            // An empty queue yields an impossible value, so any strobe fails.
            exp = (sb.size() != 0) ? sb.pop_front() : '1;
            total++;
            assert (got === exp) else begin
               bad++;
               $error("FAIL pc_action observed=0x%0h expected=0x%0h", got, exp);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_state(input logic [1:0] s, input string tag);
      int k = 0;
      while (state_o !== s && k < 20) begin
         @(negedge clk);
         k++;
      end
      check(tag, {30'd0, state_o}, {30'd0, s});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("reset_outputs",
            {24'd0, pc_inc, pc_load, imem_req, ir_load, stack_err, (pc_next != '0), state_o},
            32'd0);
      @(negedge clk);
      @(negedge clk);
      {imem_ack, br_taken, call, ret, halt, exec_done} = '0;
      model_stack.delete();
      rst = 1'b0;
      #1;
      check("release_req_low", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      check("release_req_first_edge", {31'd0, imem_req}, 32'd1);
   endtask

   task automatic do_fetch(input int waits);
      int k = 0;
      while (imem_req !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("fetch_req", {31'd0, imem_req}, 32'd1);
      repeat (waits) @(negedge clk);
      if (waits > 0) check("fetch_req_held", {31'd0, imem_req}, 32'd1);
      imem_ack = 1'b1;
      #1;
      check("ir_load_on_ack", {31'd0, ir_load}, 32'd1);
      @(negedge clk);
      imem_ack = 1'b0;
      #1;
      check("ir_load_one_cycle", {31'd0, ir_load}, 32'd0);
   endtask

   task automatic do_exec(input logic r, input logic c, input logic b,
                          input logic [AW-1:0] tgt, input logic [AW-1:0] pc);
      logic          exp_halt;
      logic [AW-1:0] addr;
      wait_state(2'b10, "reach_execute");
      // A stray ack while executing must not load the IR.
      imem_ack = 1'b1;
      #1;
      check("stray_ack_ignored", {31'd0, ir_load}, 32'd0);
      @(negedge clk);
      imem_ack = 1'b0;
      ret = r; call = c; br_taken = b; br_target = tgt; pc_in = pc;
      exec_done = 1'b1;
      exp_halt = 1'b0;
      if (r) begin
         if (model_stack.size() == 0) exp_halt = 1'b1;
         else begin
            addr = model_stack.pop_back();
            sb.push_back({2'b01, addr});
         end
      end else if (c) begin
         if (model_stack.size() == DEPTH) exp_halt = 1'b1;
         else begin
            addr = pc + 12'd1;
            model_stack.push_back(addr);
            sb.push_back({2'b01, tgt});
         end
      end else if (b) begin
         sb.push_back({2'b01, tgt});
      end else begin
         sb.push_back({2'b10, {AW{1'b0}}});
      end
      @(negedge clk);
      {exec_done, ret, call, br_taken} = '0;
      if (exp_halt) begin
         check("err_halt_state", {30'd0, state_o}, 32'd3);
         check("err_flag", {31'd0, stack_err}, 32'd1);
      end else begin
         check("first_fetch_no_req", {29'd0, imem_req, state_o}, 32'd0);
         @(negedge clk);
         check("req_after_update", {29'd0, imem_req, pc_inc, pc_load}, 32'b100);
      end
   endtask

   initial begin
      do_reset();

      // Sequential step: ack after two wait cycles.
      do_fetch(2);
      do_exec(1'b0, 1'b0, 1'b0, 12'h000, 12'h005);

      // Taken branch.
      do_fetch(1);
      do_exec(1'b0, 1'b0, 1'b1, 12'h3A0, 12'h006);

      // Call then return.
      do_fetch(0);
      do_exec(1'b0, 1'b1, 1'b0, 12'h200, 12'h010);
      do_fetch(0);
      do_exec(1'b1, 1'b0, 1'b0, 12'h000, 12'h200);

      // Nested: call outranks branch; call at last address pushes 0;
      // ret outranks call and branch; pops return in LIFO order.
      do_fetch(0);
      do_exec(1'b0, 1'b1, 1'b1, 12'h300, 12'h020);
      do_fetch(1);
      do_exec(1'b0, 1'b1, 1'b0, 12'h050, 12'hFFF);
      do_fetch(0);
      do_exec(1'b1, 1'b0, 1'b0, 12'h000, 12'h050);
      do_fetch(0);
      do_exec(1'b1, 1'b1, 1'b1, 12'h7AB, 12'h001);

      // Reset during EXECUTE with exec_done pending, one entry on the stack.
      do_fetch(0);
      do_exec(1'b0, 1'b1, 1'b0, 12'h123, 12'h040);
      do_fetch(0);
      wait_state(2'b10, "reach_execute_for_reset");
      exec_done = 1'b1;
      br_taken  = 1'b1;
      do_reset();

      // Underflow proves the stack was emptied by reset; HALT then ignores inputs.
      do_fetch(0);
      do_exec(1'b1, 1'b0, 1'b0, 12'h000, 12'h001);
      imem_ack = 1'b1; exec_done = 1'b1; ret = 1'b1; call = 1'b1;
      repeat (3) @(negedge clk);
      check("halt_ignores_inputs", {28'd0, ir_load, imem_req, state_o}, 32'b0011);
      {imem_ack, exec_done, ret, call} = '0;

      // Halt decoded in DECODE.
      do_reset();
      halt = 1'b1;
      do_fetch(0);
      @(negedge clk);
      halt = 1'b0;
      check("decode_halt", {29'd0, stack_err, state_o}, 32'b011);
      @(negedge clk);
      check("decode_halt_stays", {29'd0, imem_req, state_o}, 32'b011);

      // Overflow: fifth nested call with a four-entry stack.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         do_fetch(0);
         do_exec(1'b0, 1'b1, 1'b0, 12'h400 + 12'(i), 12'h100 + 12'(i));
      end

      @(negedge clk);
      check("scoreboard_drained", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, program address width; SHALL size pc_in, pc_next, br_target.
REQ-002 Parameter STACK_DEPTH, default 4, return-address stack entries; SHALL be a power of two, 2..16.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pc_in  input  ADDR_WIDTH  current program counter value.
REQ-006 pc_inc  output  1  one-cycle request to advance the PC by 1.
REQ-007 pc_load  output  1  one-cycle request to load pc_next into the PC.
REQ-008 pc_next  output  ADDR_WIDTH  jump/return target, valid while pc_load=1.
REQ-009 imem_req  output  1  instruction fetch request at address pc_in.
REQ-010 imem_ack  input  1  instruction memory data valid, single-cycle pulse.
REQ-011 ir_load  output  1  one-cycle strobe to latch the instruction register.
REQ-012 br_taken, call, ret, halt  input  1 each  decoded control flags, sampled as defined in REQ-018.
REQ-013 br_target  input  ADDR_WIDTH  branch/call destination.
REQ-014 exec_done  input  1  execution unit finished current instruction.
REQ-015 stack_err  output  1  sticky stack overflow/underflow flag.
REQ-016 state_o  output  2  FSM state: 00 FETCH, 01 DECODE, 10 EXECUTE, 11 HALT.

Function
REQ-017 FETCH: imem_req=1 held until imem_ack; on ack, ir_load=1 in the same cycle and next state DECODE; no timeout.
REQ-018 DECODE: one cycle; halt=1 -> HALT, with no PC update; otherwise -> EXECUTE.
REQ-019 EXECUTE: wait for exec_done; in the exec_done cycle, sample ret, call, br_taken, br_target, pc_in; decide the PC action; next state FETCH.
REQ-020 PC action priority: ret > call > br_taken > sequential.
REQ-021 ret: pop top of stack; pc_load=1, pc_next=popped address.
REQ-022 call: push pc_in+1 (modulo 2^ADDR_WIDTH); pc_load=1, pc_next=br_target.
REQ-023 br_taken only: pc_load=1, pc_next=br_target; stack unchanged.
REQ-024 Sequential (none set): pc_inc=1, pc_load=0.
REQ-025 PC action outputs are registered, asserted for exactly one cycle, coinciding with the first FETCH cycle.
REQ-026 The first FETCH cycle after EXECUTE does not assert imem_req; fetch starts in the following cycle, once the PC has updated.
REQ-027 pc_inc and pc_load are never both 1.
REQ-028 pc_next is 0 whenever pc_load=0.
REQ-029 Overflow: call with the stack holding STACK_DEPTH entries -> no push, no PC action, stack_err=1, next state HALT.
REQ-030 Underflow: ret with an empty stack -> no pop, no PC action, stack_err=1, next state HALT.
REQ-031 HALT: all strobes 0; stays until rst; inputs ignored.
REQ-032 imem_ack outside FETCH and exec_done outside EXECUTE are ignored.
REQ-033 Push return address = pc_in+1 with carry discarded; at pc_in=all-ones, push 0.

Reset
REQ-034 rst=1: state FETCH, stack empty, stack_err=0, all outputs 0, immediately and asynchronously.
REQ-035 On rst deassert, imem_req=1 from the first clock edge.
REQ-036 rst mid-fetch or mid-execute aborts the operation; no PC strobe is emitted.

Verification
REQ-037 Sequential: ack after 2 wait cycles, exec_done with no flags -> ir_load 1 cycle, pc_inc one pulse, imem_req reasserts 1 cycle later.
REQ-038 Branch: br_taken=1, br_target=0x3A0 -> pc_load=1 with pc_next=0x3A0 for one cycle, pc_inc=0.
REQ-039 Call/return: call at pc_in=0x010, target 0x200, then ret -> pc_next=0x200, then pc_next=0x011.
REQ-040 Overflow: 5 nested calls with STACK_DEPTH=4 -> 5th call produces no pc_load, stack_err=1, state_o=11.
REQ-041 Underflow and halt: ret with empty stack -> stack_err=1, HALT; separately, halt in DECODE -> HALT with no PC strobe.
REQ-042 Reset mid-EXECUTE with exec_done pending -> outputs 0, stack empty, imem_req=1 one edge after release.
